// File: rtl/write_data_pkg.sv
// Shared definitions for write_data: FSM state encodings, pair width and pair layout.
package write_data_pkg;
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_STREAM = 2'b01;
  localparam logic [1:0] ST_DRAIN  = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  localparam int PIXEL_PAIR_WIDTH = 48;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r_e;
    logic [7:0] g_e;
    logic [7:0] b_e;
    logic [7:0] r_o;
    logic [7:0] g_o;
    logic [7:0] b_o;
  } pair_t;
endpackage

// File: rtl/pair_fifo.sv
// Synchronous pixel-pair FIFO. Empty is derived from a one-cycle-delayed write
// pointer, so a freshly written entry becomes visible to the reader a cycle later.
module pair_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, wr_vis_q, rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_vis_q <= wr_ptr_q;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_vis_q == rd_ptr_q);
endmodule

// File: rtl/write_data.sv
// Captures even/odd RGB pixel pairs into a FIFO and serializes them one pixel per beat.
// Define WRITE_DATA_BGR_SWAP_EN to swap red and blue on the output (BMP byte order).
module write_data
  import write_data_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int FIFO_DEPTH   = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       horizontal_Pulse,
  input  logic [7:0] data_R_Even,
  input  logic [7:0] data_G_Even,
  input  logic [7:0] data_B_Even,
  input  logic [7:0] data_R_Odd,
  input  logic [7:0] data_G_Odd,
  input  logic [7:0] data_B_Odd,
  output logic [7:0] pixel_R,
  output logic [7:0] pixel_G,
  output logic [7:0] pixel_B,
  output logic       pixel_Valid,
  input  logic       pixel_Ready,
  output logic       pixel_Last,
  output logic       overflow_Flag,
  output logic       done_Flag
);
  localparam int TOTAL     = IMAGE_WIDTH * IMAGE_HEIGHT / 2;
  localparam int PAIRS_ROW = IMAGE_WIDTH / 2;
  localparam int CNT_W     = $clog2(TOTAL + 1);
  localparam int COL_W     = (PAIRS_ROW > 1) ? $clog2(PAIRS_ROW) : 1;
  localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PAIRS_ROW - 1);

  state_t state_q, state_d;
  pair_t  out_q, out_d, in_pair;
  logic [PIXEL_PAIR_WIDTH-1:0] fifo_rdata;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic out_vld_q, out_vld_d, odd_q, odd_d, ovf_q, ovf_d, done_q, done_d, pushed_q;
  logic cap, beat, odd_done, fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign in_pair = {data_R_Even, data_G_Even, data_B_Even, data_R_Odd, data_G_Odd, data_B_Odd};

  pair_fifo #(.WIDTH(PIXEL_PAIR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(fifo_push), .wdata(in_pair),
    .pop(fifo_pop), .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    cap       = horizontal_Pulse && (state_q == IDLE || state_q == STREAM);
    beat      = out_vld_q && pixel_Ready;
    odd_done  = beat && odd_q;
    fifo_pop  = !fifo_empty && (!out_vld_q || odd_done);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the pair.
    fifo_push = cap && (!fifo_full || fifo_pop);
    ovf_d     = ovf_q | (cap && fifo_full && !fifo_pop);
    cnt_d     = (cap && cnt_q != TOTAL_C) ? cnt_q + CNT_W'(1) : cnt_q;

    out_d     = out_q;
    out_vld_d = out_vld_q;
    odd_d     = odd_q;
    if (fifo_pop) begin
      out_d     = pair_t'(fifo_rdata);
      out_vld_d = 1'b1;
      odd_d     = 1'b0;
    end else if (odd_done) begin
      out_vld_d = 1'b0;
      odd_d     = 1'b0;
    end else if (beat) begin
      odd_d     = 1'b1;
    end

    col_d = col_q;
    if (odd_done) col_d = (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);

    state_d = state_q;
    case (state_q)
      IDLE:    if (cap) state_d = (cnt_d == TOTAL_C) ? DRAIN : STREAM;
      STREAM:  if (cnt_d == TOTAL_C) state_d = DRAIN;
      // pushed_q covers the cycle where the last write is not yet visible in empty.
      DRAIN:   if (fifo_empty && !out_vld_q && !pushed_q) state_d = DONE;
      default: state_d = DONE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      odd_q     <= 1'b0;
      cnt_q     <= '0;
      col_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      pushed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      odd_q     <= odd_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      pushed_q  <= fifo_push;
    end
  end

`ifdef WRITE_DATA_BGR_SWAP_EN
  assign pixel_R = odd_q ? out_q.b_o : out_q.b_e;
  assign pixel_B = odd_q ? out_q.r_o : out_q.r_e;
`else
  assign pixel_R = odd_q ? out_q.r_o : out_q.r_e;
  assign pixel_B = odd_q ? out_q.b_o : out_q.b_e;
`endif
  assign pixel_G       = odd_q ? out_q.g_o : out_q.g_e;
  assign pixel_Valid   = out_vld_q;
  assign pixel_Last    = out_vld_q && odd_q && (col_q == LAST_COL);
  assign overflow_Flag = ovf_q;
  assign done_Flag     = done_q;
endmodule

// File: tb/tb_write_data.sv
// Scoreboard bench for write_data: streaming, backpressure, mid-frame reset,
// post-frame input, channel order and overflow (on a taller-frame instance).
module tb_write_data;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       hp = 1'b0, hp2 = 1'b0, ready = 1'b0, ready2 = 1'b0;
  logic [7:0] re = '0, ge = '0, be = '0, ro = '0, go = '0, bo = '0;
  logic [7:0] pr, pg, pb, pr2, pg2, pb2;
  logic       pv, pl, ovf, done, pv2, pl2, ovf2, done2;

  write_data #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .horizontal_Pulse(hp),
    .data_R_Even(re), .data_G_Even(ge), .data_B_Even(be),
    .data_R_Odd(ro), .data_G_Odd(go), .data_B_Odd(bo),
    .pixel_R(pr), .pixel_G(pg), .pixel_B(pb), .pixel_Valid(pv),
    .pixel_Ready(ready), .pixel_Last(pl), .overflow_Flag(ovf), .done_Flag(done)
  );

  write_data #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .horizontal_Pulse(hp2),
    .data_R_Even(re), .data_G_Even(ge), .data_B_Even(be),
    .data_R_Odd(ro), .data_G_Odd(go), .data_B_Odd(bo),
    .pixel_R(pr2), .pixel_G(pg2), .pixel_B(pb2), .pixel_Valid(pv2),
    .pixel_Ready(ready2), .pixel_Last(pl2), .overflow_Flag(ovf2), .done_Flag(done2)
  );

  typedef struct { logic [23:0] pix; logic last; } exp_t;
  exp_t q[$];
  int total = 0, passed = 0, pair_idx = 0, beats2 = 0;
  logic hold_chk = 1'b0;
  logic [23:0] held;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [23:0] px(logic [7:0] r, logic [7:0] g, logic [7:0] b);
`ifdef WRITE_DATA_BGR_SWAP_EN
    return {b, g, r};
`else
    return {r, g, b};
`endif
  endfunction

  task automatic send_pair(input logic [7:0] a, b1, c, d, e, f);
    exp_t x;
    re = a; ge = b1; be = c; ro = d; go = e; bo = f; hp = 1'b1;
    x.pix = px(a, b1, c); x.last = 1'b0; q.push_back(x);
    x.pix = px(d, e, f);  x.last = (pair_idx % 2 == 1); q.push_back(x);
    pair_idx++;
    @(posedge clk); #1 hp = 1'b0;
  endtask

  task automatic wait_q_empty(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
  endtask

  task automatic wait_done(input int budget, string name);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk(name, done, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0; q.delete(); pair_idx = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: pops expected beats, and checks outputs hold under backpressure.
  always @(negedge clk) begin
    if (reset) begin
      if (hold_chk) begin
        chk("hold_valid", pv, 1);
        chk("hold_pixel", {pr, pg, pb}, held);
      end
      if (pv && ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got %0h want none", {pr, pg, pb});
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("beat_pixel", {pr, pg, pb}, x.pix);
          chk("beat_last", pl, x.last);
        end
      end
      hold_chk = pv && !ready;
      held = {pr, pg, pb};
      if (pv2 && ready2) beats2++;
    end else hold_chk = 1'b0;
  end

  initial begin
    // Reset state
    #3;
    chk("rst_valid", pv, 0); chk("rst_pixel", {pr, pg, pb}, 0);
    chk("rst_last", pl, 0); chk("rst_ovf", ovf, 0); chk("rst_done", done, 0);
    do_reset();

    // Basic streaming
    ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_pair(8'h10 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i),
                8'h20 + 8'(i), 8'h50 + 8'(i), 8'h60 + 8'(i));
    wait_q_empty(60);
    for (int i = 0; i < 4 && !done; i++) @(negedge clk);
    chk("done_after_last_beat", done, 1);
    chk("basic_ovf", ovf, 0);

    // Post-frame input is ignored
    @(posedge clk); #1 hp = 1'b1; re = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postframe_valid", pv, 0); chk("postframe_done", done, 1);
    end
    hp = 1'b0;
    @(negedge clk); chk("postframe_valid_late", pv, 0);

    // Backpressure with the channel-order pair first
    do_reset();
    ready = 1'b0;
    send_pair(8'hAA, 8'h55, 8'h11, 8'h01, 8'h02, 8'h03);
    send_pair(8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09);
    send_pair(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F);
    send_pair(8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6);
    for (int i = 0; i < 20 && !pv; i++) @(negedge clk);
    chk("bp_valid_rises", pv, 1);
    chk("swap_first_pixel", {pr, pg, pb}, px(8'hAA, 8'h55, 8'h11));
    repeat (10) @(posedge clk);
    #1 ready = 1'b1;
    wait_q_empty(60);
    chk("bp_ovf", ovf, 0);
    wait_done(10, "bp_done");

    // Mid-frame reset, also checks two-cycle latency
    do_reset();
    ready = 1'b0;
    send_pair(8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36);
    send_pair(8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46);
    @(negedge clk); chk("latency_not_yet", pv, 0);
    @(negedge clk); chk("latency_two", pv, 1);
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("async_valid", pv, 0); chk("async_pixel", {pr, pg, pb}, 0);
    chk("async_last", pl, 0); chk("async_ovf", ovf, 0); chk("async_done", done, 0);
    q.delete(); pair_idx = 0;
    @(posedge clk); #2 reset = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      send_pair(8'h80 + 8'(i), 8'h90 + 8'(i), 8'hA0 + 8'(i),
                8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i));
    wait_q_empty(60);
    wait_done(10, "restart_done");

    // Overflow on the 8-pair-frame instance
    do_reset();
    ready2 = 1'b0; re = 8'h12;
    hp2 = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("ovf_after_5", ovf2, 0);
    @(posedge clk); #1 hp2 = 1'b0;
    chk("ovf_after_6", ovf2, 1);
    ready2 = 1'b1;
    repeat (8) @(posedge clk);
    #1 hp2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 hp2 = 1'b0;
    for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
    chk("ovf_done", done2, 1);
    chk("ovf_beats", beats2, 14);
    chk("ovf_sticky", ovf2, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
